// File: rtl/aes_decrypt_iter_if.sv
// Start/result handshake bundle for the iterative AES-128 decryption core.
// The master side requests a block; the slave side reports ready/done/plaintext.
interface aes_decrypt_iter_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         ready;
  logic         done;
  logic [127:0] data_out;

  modport master (
    output start, key_in, data_in,
    input  ready, done, data_out
  );

  modport slave (
    input  start, key_in, data_in,
    output ready, done, data_out
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption, one inverse round per clock: 10 forward key-expansion
// cycles, one AddRoundKey, then 10 inverse rounds regenerating round keys backwards.
module aes_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_decrypt_iter_if.slave bus
);

  if (NR != 10) begin : g_nr_check
    $fatal(1, "aes_decrypt_iter supports only NR=10 (AES-128)");
  end

  typedef enum logic [1:0] {IDLE, KEXP, ADDK, DEC} state_t;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      o[119-32*c -: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      o[111-32*c -: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
      o[103-32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------- state
  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] k_q, k_d;
  logic [127:0] data_out_q, data_out_d;
  logic         done_q, done_d;

  // ---------------------------------------------------------------- key schedule
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w1p, w2p, w3p;
  logic [31:0]  sub_in, rot_w, sub_w;
  logic [31:0]  rcon_w;
  logic [127:0] k_fwd, k_prev;

  assign w0  = k_q[127:96];
  assign w1  = k_q[95:64];
  assign w2  = k_q[63:32];
  assign w3  = k_q[31:0];
  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // The four S-boxes are shared: forward expansion needs w3, backward needs w3 of the previous key.
  assign sub_in = (state_q == DEC) ? w3p : w3;
  assign rot_w  = {sub_in[23:0], sub_in[31:24]};
  assign rcon_w = {rcon_f(rnd_q), 24'h000000};

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    assign sub_w[31-8*j -: 8] = sbox(rot_w[31-8*j -: 8]);
  end

  logic [31:0] e0, e1, e2, e3;
  assign e0     = w0 ^ sub_w ^ rcon_w;
  assign e1     = w1 ^ e0;
  assign e2     = w2 ^ e1;
  assign e3     = w3 ^ e2;
  assign k_fwd  = {e0, e1, e2, e3};
  assign k_prev = {w0 ^ sub_w ^ rcon_w, w1p, w2p, w3p};

  // ---------------------------------------------------------------- inverse round
  logic [127:0] isb, t_w, imc_w;

  // InvShiftRows is pure wiring: output byte (row r, col c) takes input column (c - r) mod 4.
  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    localparam int SRC = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
    assign isb[127-8*i -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
  end

  assign t_w   = isb ^ k_prev;
  assign imc_w = inv_mix(t_w);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      st_q       <= '0;
      k_q        <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      st_q       <= st_d;
      k_q        <= k_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    st_d       = st_q;
    k_d        = k_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = bus.data_in;
          k_d     = bus.key_in;
          rnd_d   = 4'd1;
          state_d = KEXP;
        end
      end
      KEXP: begin
        k_d = k_fwd;
        if (rnd_q == 4'd10) state_d = ADDK;
        else                rnd_d   = rnd_q + 4'd1;
      end
      ADDK: begin
        st_d    = st_q ^ k_q;
        state_d = DEC;
      end
      DEC: begin
        k_d   = k_prev;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          st_d       = t_w;
          data_out_d = t_w;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          st_d = imc_w;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS vectors, handshake corner cases, and a random
// round-trip through a textbook AES-128 encryption model.
module tb_aes_decrypt_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_decrypt_iter_if bus ();
  aes_decrypt_iter #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  logic [127:0] k10_seen;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] k10;
    bit           chk_k10;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the generator-3 / inverse-generator-3 walk over the nonzero field elements.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int it = 0; it < 255; it++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_enc(input logic [127:0] pt, output logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] m [4];
    logic [7:0] acc;
    m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int i = 0; i < 16; i++) begin
        if (r < 10) begin
          acc = 0;
          for (int k = 0; k < 4; k++) acc ^= gmul(m[(k - (i%4)) & 3], t[4*(i/4) + k]);
        end else begin
          acc = t[i];
        end
        s[i] = acc ^ rk[r][127-8*i -: 8];
      end
    end
    ct = '0;
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
  endtask

  // ------------------------------------------------------------ DUT drivers
  task automatic wait_ready();
    for (int i = 0; i < 60 && !bus.ready; i++) @(negedge clk);
    chk("ready_before_start", 128'(bus.ready), 128'(1));
  endtask

  // Called at a negedge; returns right after the accepting edge E0.
  task automatic start_blk(input logic [127:0] key, input logic [127:0] data);
    bus.start   = 1'b1;
    bus.key_in  = key;
    bus.data_in = data;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges E(n0).. until done is seen; lat = -1 on timeout.
  task automatic wait_done(input int n0, output int lat, output int rdy_hi);
    lat    = -1;
    rdy_hi = 0;
    for (int n = n0; n <= 40; n++) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      if (n == 10) k10_seen = dut.k_q;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.ready) rdy_hi++;
    end
  endtask

  task automatic run_vec(input string name, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt);
    int lat, rh;
    wait_ready();
    start_blk(key, ct);
    wait_done(1, lat, rh);
    chk({name, "_latency"}, 128'(lat), 128'(21));
    chk({name, "_data_out"}, bus.data_out, pt);
    chk({name, "_ready_low_while_busy"}, 128'(rh), 128'(0));
    chk({name, "_ready_at_done"}, 128'(bus.ready), 128'(1));
  endtask

  // ------------------------------------------------------------ test
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [3];
    int           lat, rh, rh2, pulses;
    logic [127:0] key, pt, ct;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0, 1'b0};

    build_sbox();
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 128'(bus.ready), 128'(1));
    chk("reset_done", 128'(bus.done), 128'(0));
    chk("reset_data_out", bus.data_out, 128'h0);

    for (int v = 0; v < 3; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].key, vecs[v].ct, vecs[v].pt);
      if (vecs[v].chk_k10) chk($sformatf("vec%0d_round_key10", v), k10_seen, vecs[v].k10);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_done_single_cycle", v), 128'(bus.done), 128'(0));
    end

    // Back-to-back: second start raised in the done cycle of the first.
    run_vec("b2b_first", vecs[0].key, vecs[0].ct, vecs[0].pt);
    start_blk(vecs[1].key, vecs[1].ct);
    wait_done(1, lat, rh);
    chk("b2b_done_gap", 128'(lat + 1), 128'(22));
    chk("b2b_second_data", bus.data_out, vecs[1].pt);

    // start pulsed mid-run with different key/data must be ignored.
    @(posedge clk);
    @(negedge clk);
    wait_ready();
    start_blk(vecs[0].key, vecs[0].ct);
    rh2 = 0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) rh2++;
    end
    bus.start   = 1'b1;
    bus.key_in  = vecs[1].key;
    bus.data_in = vecs[1].ct;
    wait_done(6, lat, rh);
    chk("ignore_latency", 128'(lat), 128'(21));
    chk("ignore_data_out", bus.data_out, vecs[0].pt);
    chk("ignore_ready_low", 128'(rh + rh2), 128'(0));

    // Reset at E15 aborts the run with no done pulse.
    @(posedge clk);
    @(negedge clk);
    wait_ready();
    start_blk(vecs[0].key, vecs[0].ct);
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 128'(bus.ready), 128'(1));
    chk("abort_done", 128'(bus.done), 128'(0));
    chk("abort_data_out", bus.data_out, 128'h0);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort_no_done_pulse", 128'(pulses), 128'(0));
    run_vec("after_abort", vecs[0].key, vecs[0].ct, vecs[0].pt);

    // Random round-trip through the encryption model.
    for (int it = 0; it < 8; it++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      model_enc(pt, ct);
      @(negedge clk);
      run_vec($sformatf("rand%0d", it), key, ct, pt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
